lsq_dcache_arbiter: RTL and testbench

- Parametrised N-requester arbiter multiplexing load/store queue traffic onto the single D-cache port. Successor to the fixed two-way load-priority arbitration inside the LSQ top.
- Adds selectable fixed-priority or round-robin mode, a starvation guard, and owner-tagged response routing.
- Adds a flush-safe DRAIN state, so an in-flight cache transaction is never abandoned mid-access.
- Sits between load_queue/store_queue (and future prefetch/atomic requesters) and the D-cache.

---
 rtl/lsq_dcache_arbiter_pkg.sv | 26 ++
 rtl/lsq_dcache_arbiter_rr_fixed_picker.sv | 54 +++++
 rtl/lsq_dcache_arbiter.sv | 161 ++++++++++++++++
 tb/tb_lsq_dcache_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsq_dcache_arbiter_pkg.sv
// ============================================================================
// lsq_dcache_arbiter_pkg - shared D-cache port arbitration types and constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package lsq_dcache_arbiter_pkg;

  localparam int NUM_DCACHE_REQ = 2;
  localparam int DCACHE_REQ_LQ  = 0;
  localparam int DCACHE_REQ_SQ  = 1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsq_dcache_arbiter_rr_fixed_picker.sv
// ============================================================================
// rr_fixed_picker - combinational one-hot winner select, fixed or round-robin
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_fixed_picker
  import lsq_dcache_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_rr_mode,
  input  logic [NUM_REQ-1:0] i_force,
  output logic [NUM_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  logic [NUM_REQ-1:0] w_forced;
  logic [NUM_REQ-1:0] w_cand_set;
  logic               w_found;
  logic [IDX_W-1:0]   w_cand;

  assign w_forced = i_force & i_valid;
  assign o_any    = |i_valid;

  // Forced requesters shadow normal priority only in fixed mode.
  assign w_cand_set = (!i_rr_mode && (|w_forced)) ? w_forced : i_valid;

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_rr_mode) begin
        w_cand = IDX_W'((int'(i_ptr) + k) % NUM_REQ);
      end else begin
        w_cand = IDX_W'(k);
      end
      if (!w_found && w_cand_set[w_cand]) begin
        w_found          = 1'b1;
        o_idx            = w_cand;
        o_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lsq_dcache_arbiter.sv
// ============================================================================
// lsq_dcache_arbiter - N-requester LSQ to D-cache port arbiter with drain
// Revision: 1.0
// ============================================================================
`default_nettype none

module lsq_dcache_arbiter
  import lsq_dcache_arbiter_pkg::*;
#(
  parameter  int NUM_REQ      = NUM_DCACHE_REQ,
  parameter  int PRIO_MODE    = 0,
  parameter  int STARVE_LIMIT = 8,
  parameter  int ADDR_W       = 32,
  parameter  int DATA_W       = 32,
  localparam int MASK_W       = DATA_W / 8,
  localparam int IDX_W        = idx_width(NUM_REQ),
  localparam int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_flush,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0][MASK_W-1:0] i_req_rmask,
  input  logic [NUM_REQ-1:0][MASK_W-1:0] i_req_wmask,
  input  logic [NUM_REQ-1:0][DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]             o_req_grant,
  output logic [NUM_REQ-1:0]             o_req_resp,
  output logic [DATA_W-1:0]              o_resp_rdata,
  output logic [ADDR_W-1:0]              o_dcache_addr,
  output logic [MASK_W-1:0]              o_dcache_rmask,
  output logic [MASK_W-1:0]              o_dcache_wmask,
  output logic [DATA_W-1:0]              o_dcache_wdata,
  input  logic [DATA_W-1:0]              i_dcache_rdata,
  input  logic                           i_dcache_resp,
  output logic                           o_busy,
  output logic [IDX_W-1:0]               o_owner
);

  arb_state_e                     r_state, w_next_state;
  logic [IDX_W-1:0]               r_owner, r_rr_ptr;
  logic [NUM_REQ-1:0][CNT_W-1:0]  r_starve;
  logic [ADDR_W-1:0]              r_addr;
  logic [MASK_W-1:0]              r_rmask, r_wmask;
  logic [DATA_W-1:0]              r_wdata;

  logic [NUM_REQ-1:0]             w_force, w_win_oh;
  logic [IDX_W-1:0]               w_win_idx;
  logic                           w_any, w_grant_fire;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_force
      assign w_force[gi] = (PRIO_MODE == 0) && (r_starve[gi] >= CNT_W'(STARVE_LIMIT));
    end
  endgenerate

  rr_fixed_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_valid   (i_req_valid),
    .i_ptr     (r_rr_ptr),
    .i_rr_mode (PRIO_MODE != 0),
    .i_force   (w_force),
    .o_onehot  (w_win_oh),
    .o_idx     (w_win_idx),
    .o_any     (w_any)
  );

  assign w_grant_fire = !rst && (r_state == ARB_IDLE) && !i_flush && w_any;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    o_req_grant    = '0;
    o_req_resp     = '0;
    o_resp_rdata   = '0;
    o_dcache_addr  = '0;
    o_dcache_rmask = '0;
    o_dcache_wmask = '0;
    o_dcache_wdata = '0;
    o_busy         = 1'b0;
    o_owner        = '0;
    if (!rst) begin
      o_busy  = (r_state != ARB_IDLE);
      o_owner = r_owner;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_fire) begin
            o_req_grant    = w_win_oh;
            o_dcache_addr  = i_req_addr[w_win_idx];
            o_dcache_rmask = i_req_rmask[w_win_idx];
            o_dcache_wmask = i_req_wmask[w_win_idx];
            o_dcache_wdata = i_req_wdata[w_win_idx];
            w_next_state   = ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          o_dcache_addr  = r_addr;
          o_dcache_rmask = r_rmask;
          o_dcache_wmask = r_wmask;
          o_dcache_wdata = r_wdata;
          if (i_dcache_resp) begin
            o_req_resp[r_owner] = 1'b1;
            o_resp_rdata        = i_dcache_rdata;
            w_next_state        = ARB_IDLE;
          end else if (i_flush) begin
            w_next_state = ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          // Cache access completes but its response belongs to a flushed owner.
          o_dcache_addr  = r_addr;
          o_dcache_rmask = r_rmask;
          o_dcache_wmask = r_wmask;
          o_dcache_wdata = r_wdata;
          if (i_dcache_resp) begin
            w_next_state = ARB_IDLE;
          end
        end
        default: w_next_state = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_starve <= '0;
      r_addr   <= '0;
      r_rmask  <= '0;
      r_wmask  <= '0;
      r_wdata  <= '0;
    end else if (w_grant_fire) begin
      r_owner  <= w_win_idx;
      r_addr   <= i_req_addr[w_win_idx];
      r_rmask  <= i_req_rmask[w_win_idx];
      r_wmask  <= i_req_wmask[w_win_idx];
      r_wdata  <= i_req_wdata[w_win_idx];
      r_rr_ptr <= (w_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if ((PRIO_MODE == 0) && i_req_valid[i] && !w_win_oh[i]) begin
          r_starve[i] <= (r_starve[i] >= CNT_W'(STARVE_LIMIT)) ? CNT_W'(STARVE_LIMIT)
                                                                : r_starve[i] + 1'b1;
        end else begin
          r_starve[i] <= '0;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsq_dcache_arbiter.sv
// ============================================================================
// tb_lsq_dcache_arbiter - scoreboard bench, fixed-priority and round-robin DUTs
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lsq_dcache_arbiter;

  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int MW  = DW / 8;
  localparam int LIM = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst = 1'b1;
  logic                   flush = 1'b0;
  logic [N-1:0]           req_valid = '0;
  logic [N-1:0][AW-1:0]   req_addr = '0;
  logic [N-1:0][MW-1:0]   req_rmask = '0;
  logic [N-1:0][MW-1:0]   req_wmask = '0;
  logic [N-1:0][DW-1:0]   req_wdata = '0;
  logic [DW-1:0]          dc_rdata = '0;
  logic                   dc_resp = 1'b0;

  logic [N-1:0]  gnt   [2];
  logic [N-1:0]  rsp   [2];
  logic [DW-1:0] rdata [2];
  logic [AW-1:0] dc_addr [2];
  logic [MW-1:0] dc_rm [2];
  logic [MW-1:0] dc_wm [2];
  logic [DW-1:0] dc_wd [2];
  logic          bsy   [2];
  logic [1:0]    own   [2];

  lsq_dcache_arbiter #(
    .NUM_REQ(N), .PRIO_MODE(0), .STARVE_LIMIT(LIM), .ADDR_W(AW), .DATA_W(DW)
  ) u_fix (
    .clk(clk), .rst(rst), .i_flush(flush), .i_req_valid(req_valid),
    .i_req_addr(req_addr), .i_req_rmask(req_rmask), .i_req_wmask(req_wmask),
    .i_req_wdata(req_wdata), .o_req_grant(gnt[0]), .o_req_resp(rsp[0]),
    .o_resp_rdata(rdata[0]), .o_dcache_addr(dc_addr[0]), .o_dcache_rmask(dc_rm[0]),
    .o_dcache_wmask(dc_wm[0]), .o_dcache_wdata(dc_wd[0]), .i_dcache_rdata(dc_rdata),
    .i_dcache_resp(dc_resp), .o_busy(bsy[0]), .o_owner(own[0])
  );

  lsq_dcache_arbiter #(
    .NUM_REQ(N), .PRIO_MODE(1), .STARVE_LIMIT(8), .ADDR_W(AW), .DATA_W(DW)
  ) u_rr (
    .clk(clk), .rst(rst), .i_flush(flush), .i_req_valid(req_valid),
    .i_req_addr(req_addr), .i_req_rmask(req_rmask), .i_req_wmask(req_wmask),
    .i_req_wdata(req_wdata), .o_req_grant(gnt[1]), .o_req_resp(rsp[1]),
    .o_resp_rdata(rdata[1]), .o_dcache_addr(dc_addr[1]), .o_dcache_rmask(dc_rm[1]),
    .o_dcache_wmask(dc_wm[1]), .o_dcache_wdata(dc_wd[1]), .i_dcache_rdata(dc_rdata),
    .i_dcache_resp(dc_resp), .o_busy(bsy[1]), .o_owner(own[1])
  );

  typedef struct {
    bit            kind;   // 0 = grant, 1 = response
    logic [N-1:0]  vec;
    logic [AW-1:0] addr;
    logic [MW-1:0] rm;
    logic [MW-1:0] wm;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
  } txn_t;

  txn_t q_fix[$];
  txn_t q_rr[$];

  // Reference model: 0 idle, 1 waiting on cache, 2 draining a flushed access
  int            m_state = 0;
  int            m_owner [2];
  int            m_ptr = 0;
  int            m_cnt [N];
  logic [AW-1:0] m_haddr [2];
  logic [MW-1:0] m_hrm [2];
  logic [MW-1:0] m_hwm [2];
  logic [DW-1:0] m_hwd [2];
  bit            cur_rst, cur_busy, cur_gnt, cur_rsp;
  bit            started = 1'b0;

  logic [N-1:0][AW-1:0] stg_addr;
  logic [N-1:0][MW-1:0] stg_rm, stg_wm;
  logic [N-1:0][DW-1:0] stg_wd;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  function automatic int pick_fixed(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i] && m_cnt[i] >= LIM) return i;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic int pick_rr(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (v[j]) return j;
    end
    return 0;
  endfunction

  function automatic txn_t mk_grant(input int w);
    txn_t t;
    t.kind = 1'b0;
    t.vec  = N'(1) << w;
    t.addr = req_addr[w];
    t.rm   = req_rmask[w];
    t.wm   = req_wmask[w];
    t.wd   = req_wdata[w];
    t.rd   = '0;
    return t;
  endfunction

  function automatic txn_t mk_resp(input int w, input logic [DW-1:0] rd);
    txn_t t;
    t.kind = 1'b1;
    t.vec  = N'(1) << w;
    t.addr = '0;
    t.rm   = '0;
    t.wm   = '0;
    t.wd   = '0;
    t.rd   = rd;
    return t;
  endfunction

  task automatic hold(input int d, input int w);
    m_haddr[d] = req_addr[w];
    m_hrm[d]   = req_rmask[w];
    m_hwm[d]   = req_wmask[w];
    m_hwd[d]   = req_wdata[w];
    m_owner[d] = w;
  endtask

  task automatic model_cycle();
    int wf, wr;
    cur_rst  = rst;
    cur_gnt  = 1'b0;
    cur_rsp  = 1'b0;
    cur_busy = (m_state != 0) && !rst;
    if (rst) begin
      m_state = 0;
      m_ptr   = 0;
      m_owner[0] = 0;
      m_owner[1] = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    case (m_state)
      0: if (!flush && req_valid != '0) begin
        wf = pick_fixed(req_valid);
        wr = pick_rr(req_valid);
        q_fix.push_back(mk_grant(wf));
        q_rr.push_back(mk_grant(wr));
        hold(0, wf);
        hold(1, wr);
        for (int i = 0; i < N; i++)
          m_cnt[i] = (req_valid[i] && i != wf) ? ((m_cnt[i] + 1 > LIM) ? LIM : m_cnt[i] + 1) : 0;
        m_ptr   = (wr + 1) % N;
        cur_gnt = 1'b1;
        m_state = 1;
      end
      1: if (dc_resp) begin
        q_fix.push_back(mk_resp(m_owner[0], dc_rdata));
        q_rr.push_back(mk_resp(m_owner[1], dc_rdata));
        cur_rsp = 1'b1;
        m_state = 0;
      end else if (flush) begin
        m_state = 2;
      end
      default: if (dc_resp) m_state = 0;
    endcase
  endtask

  task automatic stage(input int i, input logic [AW-1:0] a, input logic [MW-1:0] rm,
                       input logic [MW-1:0] wm, input logic [DW-1:0] wd);
    stg_addr[i] = a;
    stg_rm[i]   = rm;
    stg_wm[i]   = wm;
    stg_wd[i]   = wd;
  endtask

  task automatic step(input bit r, input bit f, input logic [N-1:0] v, input bit resp,
                      input logic [DW-1:0] rd, input bit rnd);
    @(posedge clk);
    #1;
    if (rnd) begin
      for (int i = 0; i < N; i++)
        stage(i, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
    end
    rst       = r;
    flush     = f;
    req_valid = v;
    dc_resp   = resp;
    dc_rdata  = rd;
    req_addr  = stg_addr;
    req_rmask = stg_rm;
    req_wmask = stg_wm;
    req_wdata = stg_wd;
    model_cycle();
    started = 1'b1;
  endtask

  function automatic bit pop(input int d, output txn_t t);
    if (d == 0) begin
      if (q_fix.size() == 0) return 1'b0;
      t = q_fix.pop_front();
    end else begin
      if (q_rr.size() == 0) return 1'b0;
      t = q_rr.pop_front();
    end
    return 1'b1;
  endfunction

  task automatic check_dut(input int d);
    txn_t t;
    if (cur_rst) begin
      chk("rst_outputs_zero", d,
          64'(|{gnt[d], rsp[d], rdata[d], dc_addr[d], dc_rm[d], dc_wm[d], dc_wd[d], bsy[d], own[d]}), 0);
      return;
    end
    chk("busy", d, 64'(bsy[d]), 64'(cur_busy));
    chk("grant_present", d, 64'(gnt[d] != '0), 64'(cur_gnt));
    chk("resp_present", d, 64'(rsp[d] != '0), 64'(cur_rsp));
    if (gnt[d] != '0) begin
      if (!pop(d, t)) begin
        chk("grant_expected_entry", d, 0, 1);
      end else begin
        chk("grant_kind", d, 64'(t.kind), 0);
        chk("grant_vec", d, 64'(gnt[d]), 64'(t.vec));
        chk("grant_addr", d, 64'(dc_addr[d]), 64'(t.addr));
        chk("grant_masks", d, 64'({dc_rm[d], dc_wm[d]}), 64'({t.rm, t.wm}));
        chk("grant_wdata", d, 64'(dc_wd[d]), 64'(t.wd));
      end
    end
    if (rsp[d] != '0) begin
      if (!pop(d, t)) begin
        chk("resp_expected_entry", d, 0, 1);
      end else begin
        chk("resp_kind", d, 64'(t.kind), 1);
        chk("resp_vec", d, 64'(rsp[d]), 64'(t.vec));
        chk("resp_rdata", d, 64'(rdata[d]), 64'(t.rd));
      end
    end
    if (!bsy[d] && gnt[d] == '0) begin
      chk("idle_dcache_zero", d, 64'(|{dc_addr[d], dc_rm[d], dc_wm[d], dc_wd[d]}), 0);
    end
    if (bsy[d]) begin
      chk("held_addr", d, 64'(dc_addr[d]), 64'(m_haddr[d]));
      chk("held_mask_data", d, 64'({dc_rm[d], dc_wm[d], dc_wd[d]}), 64'({m_hrm[d], m_hwm[d], m_hwd[d]}));
      chk("owner", d, 64'(own[d]), 64'(m_owner[d]));
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) check_dut(d);
    end
  end

  initial begin
    for (int i = 0; i < N; i++) stage(i, 32'h1000 + 32'(i * 16), 4'hF, 4'h0, 32'(i));
    step(1, 0, 4'b0000, 0, 0, 0);
    step(1, 0, 4'b0011, 0, 0, 0);

    // Two loads contend; response after three cycles, then the second requester.
    step(0, 0, 4'b0011, 0, 0, 0);
    step(0, 0, 4'b0011, 0, 0, 0);
    step(0, 0, 4'b0011, 0, 0, 0);
    step(0, 0, 4'b0011, 1, 32'hDEADBEEF, 0);
    step(0, 0, 4'b0010, 0, 0, 0);
    step(0, 0, 4'b0010, 1, 32'h1111, 0);

    // Persistent contention to exercise starvation and pointer rotation.
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 4'b0011, 0, 0, 0);
      step(0, 0, 4'b0011, 1, 32'(k + 32'h200), 0);
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 4'b1111, 0, 0, 0);
      step(0, 0, 4'b1111, 1, 32'(k + 32'h300), 0);
    end

    // Store flushed mid-access: requester drops, held copy keeps driving.
    stage(1, 32'h100, 4'h0, 4'hC, 32'hCAFE0001);
    step(0, 0, 4'b0010, 0, 0, 0);
    stage(1, 32'h0, 4'h0, 4'h0, 32'h0);
    step(0, 0, 4'b0010, 0, 0, 0);
    step(0, 1, 4'b0000, 0, 0, 0);
    step(0, 0, 4'b0000, 0, 0, 0);
    step(0, 1, 4'b0000, 1, 32'hBAD0BAD0, 0);
    step(0, 0, 4'b0000, 0, 0, 0);

    // Flush in the same cycle as the response still delivers it.
    step(0, 0, 4'b0100, 0, 0, 0);
    step(0, 1, 4'b0100, 1, 32'h5A5A5A5A, 0);
    step(0, 1, 4'b0100, 0, 0, 0);
    step(0, 0, 4'b0000, 0, 0, 0);

    // Reset in the middle of a transaction.
    step(0, 0, 4'b1000, 0, 0, 0);
    step(0, 0, 4'b1000, 0, 0, 0);
    step(1, 0, 4'b1000, 1, 32'h77, 0);
    step(0, 0, 4'b1110, 0, 0, 0);
    step(0, 0, 4'b1110, 1, 32'h78, 0);

    for (int c = 0; c < 1500; c++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0), 4'($urandom),
           ($urandom_range(0, 2) == 0), $urandom, 1);
    end
    for (int c = 0; c < 4; c++) step(0, 0, 4'b0000, 1, 32'h0, 0);

    @(negedge clk);
    #1;
    chk("scoreboard_empty", 0, 64'(q_fix.size() + q_rr.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
